sm_clk_ctrl: RTL and testbench
==============================

Name: sm_clk_ctrl

Overview:
Parametrised clock-control unit for the schoolMIPS core. It replaces the fixed divide-and-gate scheme with one-cycle CPU enable pulses on the system clock. It supports four modes: free run, pause, single step and N-step burst. The step button is synchronised and debounced inside the block. The board top drives it from keys/switches, and `cpuEn` feeds the core's clock-enable.

Parameters:
- DIV_W, 5, width of `clkDevide`; tick period is 2^clkDevide cycles, so the exponent range is 0..2^DIV_W-1.
- CNT_W, 32, width of the divider counter; must be ≥ 2^DIV_W (exponent values ≥ CNT_W saturate to CNT_W-1).
- DEB_W, 16, debounce counter width; an input level is accepted after 2^DEB_W stable cycles.
- BURST_W, 8, width of `burstLen` and the burst counter.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- clkDevide, input, DIV_W, divide exponent.
- mode, input, 2, operating mode: 00 RUN, 01 PAUSE, 10 STEP, 11 BURST.
- stepBtn, input, 1, raw asynchronous step button, active-high.
- burstLen, input, BURST_W, number of enables issued per burst request.
- cpuEn, output, 1, one-cycle CPU enable pulse.
- running, output, 1, high while the FSM is in RUN or BURST_ACT.
- tickCnt, output, 32, count of cpuEn pulses issued; wraps.
- stepSeen, output, 1, one-cycle pulse per accepted step request.

Behaviour:
- Reset values: cpuEn=0, running=0, tickCnt=0, stepSeen=0. Divider counter=0, debounced level=0, FSM=PAUSED, synchroniser flops=0.
- Synchroniser: two flops on stepBtn.
- Debounce:
  - Counter clears whenever the synced value differs from the accepted level.
  - When the counter reaches all-ones with the value still differing, the accepted level updates and the counter clears.
  - A 0→1 transition of the accepted level produces a step request, visible as stepSeen on the same cycle.
- Divider:
  - Counter increments every cycle.
  - tick=1 when counter ≥ (1<<e)-1, where e=min(clkDevide, CNT_W-1); the counter then returns to 0.
  - clkDevide=0 gives tick every cycle.
  - Lowering clkDevide mid-count produces a tick on the next cycle (≥ compare), with no lockup.
- FSM states: PAUSED, RUN, STEP_WAIT, BURST_ACT.
  - PAUSED: mode=00 → RUN. Step request with mode=10 → STEP_WAIT. Step request with mode=11 and burstLen≠0 → BURST_ACT, burst counter loaded with burstLen. Step request with burstLen=0 is ignored.
  - RUN: cpuEn=tick. mode≠00 → PAUSED on the next cycle; no enable is issued in that cycle.
  - STEP_WAIT: on the first tick, cpuEn=1 and → PAUSED. Additional step requests while waiting are dropped, not queued.
  - BURST_ACT: each tick gives cpuEn=1 and decrements the counter. The tick that takes the counter to 0 gives the last pulse and → PAUSED. Step requests during a burst are ignored.
- Mode change mid-operation: any change of mode while in STEP_WAIT or BURST_ACT aborts to PAUSED next cycle. No further pulse is issued and the burst counter clears.
- cpuEn is registered: it asserts one cycle after the tick compare. It is never high for two consecutive cycles unless clkDevide=0 in RUN or BURST_ACT.
- tickCnt increments on every cycle cpuEn=1 and wraps 0xFFFFFFFF→0.
- Reset mid-burst or mid-debounce returns everything to reset values immediately (asynchronous).

Optional Feature:
- Macro: SM_CLK_CTRL_BREAK_EN.
- When defined, adds these ports:
  - pc (input, 32)
  - bpAddr (input, 32)
  - bpValid (input, 1)
  - halted (output, 1, reset 0)
- In RUN, a cycle with cpuEn=1, bpValid=1 and pc==bpAddr sets halted and forces the FSM to PAUSED, even though mode=00. While halted=1, RUN entry is blocked.
- A step request clears halted. The step is also processed normally, so in mode 10 one STEP_WAIT enable is issued.
- When the macro is undefined, none of these ports or logic exist, and RUN continues unconditionally.

Test Plan:
1. Bench parameters DEB_W=3. Reset, then mode=00 with clkDevide=2 → cpuEn pulses every 4th cycle; after 40 cycles tickCnt=10.
2. mode=10, stepBtn held high for 12 cycles → exactly one stepSeen and exactly one cpuEn. Repeat with the button bouncing (1-cycle glitches) → still exactly one of each.
3. mode=11, burstLen=5, clkDevide=1, one clean press → 5 cpuEn pulses 2 cycles apart, then running=0. burstLen=0 press → no pulses.
4. Burst of 200 with mode switched to 01 after 3 pulses → no further pulses; tickCnt=3 above its start value.
5. RUN with clkDevide=10, switch to 0 mid-count → tick on the next cycle, then every cycle. Assert rst mid-run → all outputs 0 asynchronously.
6. (SM_CLK_CTRL_BREAK_EN) RUN, bpAddr=0x10, pc=0x10 at the third pulse → halted=1, no fourth pulse. Step press in mode 10 → halted=0 and one pulse.

Source files
------------

// File: rtl/sm_clk_ctrl.sv
// sm_clk_ctrl: CPU clock-enable generator for schoolMIPS with run, pause, single-step and N-step burst modes.
// Defining SM_CLK_CTRL_BREAK_EN adds a PC breakpoint that halts RUN mode.
module sm_clk_ctrl #(
  parameter int DIV_W   = 5,
  parameter int CNT_W   = 32,
  parameter int DEB_W   = 16,
  parameter int BURST_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DIV_W-1:0]   clkDevide,
  input  logic [1:0]         mode,
  input  logic               stepBtn,
  input  logic [BURST_W-1:0] burstLen,
  output logic               cpuEn,
  output logic               running,
  output logic [31:0]        tickCnt,
  output logic               stepSeen
`ifdef SM_CLK_CTRL_BREAK_EN
  ,
  input  logic [31:0]        pc,
  input  logic [31:0]        bpAddr,
  input  logic               bpValid,
  output logic               halted
`endif
);

  typedef enum logic [1:0] {
    S_PAUSED    = 2'd0,
    S_RUN       = 2'd1,
    S_STEP_WAIT = 2'd2,
    S_BURST_ACT = 2'd3
  } state_t;

  localparam logic [1:0] M_RUN   = 2'b00;
  localparam logic [1:0] M_STEP  = 2'b10;
  localparam logic [1:0] M_BURST = 2'b11;

  logic               sync1_q, sync2_q;
  logic               deb_lvl_q;
  logic [DEB_W-1:0]   deb_cnt_q;
  logic               deb_differs, deb_done;
  logic               step_req_d, stepSeen_q;

  logic [31:0]        div_exp;
  logic [CNT_W-1:0]   div_cnt_q, div_cnt_d, div_thresh;
  logic               tick;

  state_t             state_q;
  logic [BURST_W-1:0] burst_cnt_q;
  logic               cpuEn_q, running_q;
  logic [31:0]        tick_cnt_q;
  logic               bp_hit, run_block;

  // Debounce: count consecutive cycles the synced button disagrees with the accepted level.
  assign deb_differs = (sync2_q != deb_lvl_q);
  assign deb_done    = deb_differs && (&deb_cnt_q);
  assign step_req_d  = deb_done && sync2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_lvl_q  <= 1'b0;
      deb_cnt_q  <= '0;
      stepSeen_q <= 1'b0;
    end else begin
      sync1_q    <= stepBtn;
      sync2_q    <= sync1_q;
      stepSeen_q <= step_req_d;
      if (!deb_differs || deb_done)
        deb_cnt_q <= '0;
      else
        deb_cnt_q <= deb_cnt_q + DEB_W'(1);
      if (deb_done)
        deb_lvl_q <= sync2_q;
    end
  end

  // A >= compare lets a lowered exponent fire immediately instead of waiting for a wrap.
  always_comb begin
    div_exp = 32'(clkDevide);
    if (div_exp > 32'(CNT_W - 1))
      div_exp = 32'(CNT_W - 1);
    div_thresh = (CNT_W'(1) << div_exp) - CNT_W'(1);
    tick       = (div_cnt_q >= div_thresh);
    div_cnt_d  = tick ? '0 : div_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      div_cnt_q <= '0;
    else
      div_cnt_q <= div_cnt_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_PAUSED;
      burst_cnt_q <= '0;
      cpuEn_q     <= 1'b0;
      running_q   <= 1'b0;
      tick_cnt_q  <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + 32'(cpuEn_q);
      cpuEn_q    <= 1'b0;
      running_q  <= 1'b0;
      case (state_q)
        S_PAUSED: begin
          if (mode == M_RUN && !run_block) begin
            state_q   <= S_RUN;
            running_q <= 1'b1;
          end else if (stepSeen_q && mode == M_STEP) begin
            state_q <= S_STEP_WAIT;
          end else if (stepSeen_q && mode == M_BURST && burstLen != '0) begin
            state_q     <= S_BURST_ACT;
            burst_cnt_q <= burstLen;
            running_q   <= 1'b1;
          end
        end
        S_RUN: begin
          if (mode != M_RUN || bp_hit) begin
            state_q <= S_PAUSED;
          end else begin
            cpuEn_q   <= tick;
            running_q <= 1'b1;
          end
        end
        S_STEP_WAIT: begin
          if (mode != M_STEP) begin
            state_q <= S_PAUSED;
          end else if (tick) begin
            cpuEn_q <= 1'b1;
            state_q <= S_PAUSED;
          end
        end
        S_BURST_ACT: begin
          if (mode != M_BURST) begin
            state_q     <= S_PAUSED;
            burst_cnt_q <= '0;
          end else begin
            running_q <= 1'b1;
            if (tick) begin
              cpuEn_q     <= 1'b1;
              burst_cnt_q <= burst_cnt_q - BURST_W'(1);
              if (burst_cnt_q == BURST_W'(1)) begin
                state_q   <= S_PAUSED;
                running_q <= 1'b0;
              end
            end
          end
        end
        default: state_q <= S_PAUSED;
      endcase
    end
  end

`ifdef SM_CLK_CTRL_BREAK_EN
  logic halted_q;

  // The breakpoint is checked on the pulse cycle itself, so the matching instruction is the last one run.
  assign bp_hit    = (state_q == S_RUN) && cpuEn_q && bpValid && (pc == bpAddr);
  assign run_block = halted_q;
  assign halted    = halted_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      halted_q <= 1'b0;
    else if (bp_hit)
      halted_q <= 1'b1;
    else if (stepSeen_q)
      halted_q <= 1'b0;
  end
`else
  assign bp_hit    = 1'b0;
  assign run_block = 1'b0;
`endif

  assign cpuEn    = cpuEn_q;
  assign running  = running_q;
  assign tickCnt  = tick_cnt_q;
  assign stepSeen = stepSeen_q;

endmodule

// File: tb/tb_sm_clk_ctrl.sv
// Self-checking bench for sm_clk_ctrl: vector table for step/burst presses plus hand sequences
// for RUN, burst abort, divider change, asynchronous reset and (when enabled) breakpoints.
module tb_sm_clk_ctrl;
  localparam int DIV_W   = 5;
  localparam int CNT_W   = 32;
  localparam int DEB_W   = 3;
  localparam int BURST_W = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [DIV_W-1:0]   clkDevide;
  logic [1:0]         mode;
  logic               stepBtn;
  logic [BURST_W-1:0] burstLen;
  logic               cpuEn;
  logic               running;
  logic [31:0]        tickCnt;
  logic               stepSeen;
`ifdef SM_CLK_CTRL_BREAK_EN
  logic [31:0]        pc;
  logic [31:0]        bpAddr;
  logic               bpValid;
  logic               halted;
`endif

  always #5 clk = ~clk;

  sm_clk_ctrl #(
    .DIV_W   (DIV_W),
    .CNT_W   (CNT_W),
    .DEB_W   (DEB_W),
    .BURST_W (BURST_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clkDevide (clkDevide),
    .mode      (mode),
    .stepBtn   (stepBtn),
    .burstLen  (burstLen),
    .cpuEn     (cpuEn),
    .running   (running),
    .tickCnt   (tickCnt),
    .stepSeen  (stepSeen)
`ifdef SM_CLK_CTRL_BREAK_EN
    ,
    .pc        (pc),
    .bpAddr    (bpAddr),
    .bpValid   (bpValid),
    .halted    (halted)
`endif
  );

  // Output monitor, sampled 1 time unit after each rising edge.
  int cyc = 0;
  int pulse_total = 0;
  int seen_total = 0;
  int pulse_cyc[$];

  always @(posedge clk) begin
    #1;
    cyc++;
    if (cpuEn === 1'b1) begin
      pulse_total++;
      pulse_cyc.push_back(cyc);
    end
    if (stepSeen === 1'b1)
      seen_total++;
  end

  // Scoreboard of expected values, queued when stimulus is applied.
  typedef struct {
    string       name;
    logic [63:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;

  task automatic sb_push(input string name, input logic [63:0] v);
    exp_t e;
    e.name = name;
    e.exp  = v;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input logic [63:0] act);
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: actual %0d, no required value queued", act);
    end else begin
      e = sb_q.pop_front();
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: actual %0d, required %0d", e.name, act, e.exp);
      end else begin
        $display("ok   %s: %0d", e.name, act);
      end
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // style 1: clean 12-cycle press; style 2: bouncy press with 1-cycle glitches.
  task automatic press(input int style);
    logic [23:0] bounce;
    bounce = 24'b101101001_111111111111_010;
    if (style == 2) begin
      for (int i = 23; i >= 0; i--) begin
        stepBtn = bounce[i];
        @(negedge clk);
      end
    end else begin
      stepBtn = 1'b1;
      cycles(12);
    end
    stepBtn = 1'b0;
  endtask

  task automatic gap_range(input int from, output int mn, output int mx);
    mn = 1000000;
    mx = 0;
    for (int i = from + 1; i < pulse_cyc.size(); i++) begin
      if (pulse_cyc[i] - pulse_cyc[i-1] < mn) mn = pulse_cyc[i] - pulse_cyc[i-1];
      if (pulse_cyc[i] - pulse_cyc[i-1] > mx) mx = pulse_cyc[i] - pulse_cyc[i-1];
    end
  endtask

  typedef struct {
    logic [1:0]         mode;
    logic [DIV_W-1:0]   div;
    logic [BURST_W-1:0] blen;
    int                 style;
    int                 exp_pulses;
    int                 exp_seen;
    int                 exp_gap;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual timeout, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0, s0, idx0, mn, mx, waited;
    logic [31:0] t0;

    vecs[0] = '{2'b10, 5'd2, 8'd0, 1, 1, 1, 0};
    vecs[1] = '{2'b10, 5'd2, 8'd0, 2, 1, 1, 0};
    vecs[2] = '{2'b11, 5'd1, 8'd5, 1, 5, 1, 2};
    vecs[3] = '{2'b11, 5'd1, 8'd0, 1, 0, 1, 0};
    vecs[4] = '{2'b01, 5'd0, 8'd3, 1, 0, 1, 0};

    mode      = 2'b00;
    clkDevide = 5'd2;
    stepBtn   = 1'b0;
    burstLen  = '0;
`ifdef SM_CLK_CTRL_BREAK_EN
    pc      = '0;
    bpAddr  = '0;
    bpValid = 1'b0;
`endif

    rst = 1'b1;
    cycles(3);
    sb_push("reset_cpuEn", 0);    sb_check(cpuEn);
    sb_push("reset_running", 0);  sb_check(running);
    sb_push("reset_tickCnt", 0);  sb_check(tickCnt);
    sb_push("reset_stepSeen", 0); sb_check(stepSeen);
    rst = 1'b0;

    // RUN with divide exponent 2: one pulse every 4 cycles.
    cycles(12);
    t0   = tickCnt;
    idx0 = pulse_cyc.size();
    sb_push("run_tickcnt_40cyc", 10);
    sb_push("run_gap_min", 4);
    sb_push("run_gap_max", 4);
    cycles(40);
    sb_check(32'(tickCnt - t0));
    gap_range(idx0, mn, mx);
    sb_check(mn);
    sb_check(mx);

    for (int v = 0; v < 5; v++) begin
      mode      = vecs[v].mode;
      clkDevide = vecs[v].div;
      burstLen  = vecs[v].blen;
      cycles(6);
      p0   = pulse_total;
      s0   = seen_total;
      idx0 = pulse_cyc.size();
      sb_push($sformatf("vec%0d_pulses", v), vecs[v].exp_pulses);
      sb_push($sformatf("vec%0d_stepSeen", v), vecs[v].exp_seen);
      sb_push($sformatf("vec%0d_running_end", v), 0);
      if (vecs[v].exp_gap != 0) begin
        sb_push($sformatf("vec%0d_gap_min", v), vecs[v].exp_gap);
        sb_push($sformatf("vec%0d_gap_max", v), vecs[v].exp_gap);
      end
      press(vecs[v].style);
      cycles(40);
      sb_check(pulse_total - p0);
      sb_check(seen_total - s0);
      sb_check(running);
      if (vecs[v].exp_gap != 0) begin
        gap_range(idx0, mn, mx);
        sb_check(mn);
        sb_check(mx);
      end
    end

    // Burst of 200 aborted by a mode change after the third pulse.
    mode      = 2'b11;
    clkDevide = 5'd1;
    burstLen  = 8'd200;
    cycles(6);
    p0     = pulse_total;
    t0     = tickCnt;
    waited = 0;
    stepBtn = 1'b1;
    while ((pulse_total - p0) < 3 && waited < 200) begin
      @(negedge clk);
      waited++;
      if (waited == 12) stepBtn = 1'b0;
    end
    stepBtn = 1'b0;
    sb_push("burst_running_mid", 1);
    sb_check(running);
    mode = 2'b01;
    cycles(30);
    sb_push("burst_abort_pulses", 3);   sb_check(pulse_total - p0);
    sb_push("burst_abort_tickcnt", 3);  sb_check(32'(tickCnt - t0));
    sb_push("burst_abort_running", 0);  sb_check(running);

    // RUN at exponent 10, then drop to 0 mid-count.
    mode      = 2'b00;
    clkDevide = 5'd10;
    cycles(1);
    p0 = pulse_total;
    sb_push("div10_no_pulse_20cyc", 0);
    cycles(20);
    sb_check(pulse_total - p0);
    clkDevide = 5'd0;
    sb_push("div0_next_cycle_cpuEn", 1);
    @(negedge clk);
    sb_check(cpuEn);
    p0 = pulse_total;
    sb_push("div0_every_cycle", 5);
    cycles(5);
    sb_check(pulse_total - p0);

    // Asynchronous reset between clock edges.
    #1 rst = 1'b1;
    #1;
    sb_push("async_rst_cpuEn", 0);    sb_check(cpuEn);
    sb_push("async_rst_running", 0);  sb_check(running);
    sb_push("async_rst_tickCnt", 0);  sb_check(tickCnt);
    sb_push("async_rst_stepSeen", 0); sb_check(stepSeen);
    mode      = 2'b01;
    clkDevide = 5'd2;
    @(negedge clk);
    rst = 1'b0;
    cycles(2);

`ifdef SM_CLK_CTRL_BREAK_EN
    // Breakpoint on the third RUN pulse, then a single step clears the halt.
    bpAddr  = 32'h10;
    bpValid = 1'b1;
    pc      = 32'h0;
    mode    = 2'b00;
    p0      = pulse_total;
    waited  = 0;
    while ((pulse_total - p0) < 2 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    pc = 32'h10;
    cycles(30);
    sb_push("bp_halted", 1);      sb_check(halted);
    sb_push("bp_pulses", 3);      sb_check(pulse_total - p0);
    sb_push("bp_running", 0);     sb_check(running);
    pc   = 32'h0;
    mode = 2'b10;
    cycles(4);
    p0 = pulse_total;
    sb_push("bp_step_halted", 0);
    sb_push("bp_step_pulses", 1);
    press(1);
    cycles(40);
    sb_check(halted);
    sb_check(pulse_total - p0);
`endif

    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: actual none, required %0d", e.name, e.exp);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
